// File: rtl/calc_dp.sv
// Small calculator datapath: A/B operand registers, 4-bit ALU, combinational multiplier,
// restoring divider and selectable output registers. Optional macro: CALC_DP_DIVZERO_FAST_EN.
module calc_dp (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       EN_X,
  input  logic       EN_Y,
  input  logic       EN_F,
  input  logic       Go_Calc,
  input  logic [1:0] Op_Calc,
  input  logic       Go_DIV,
  input  logic       Sel_H,
  input  logic [1:0] Sel_L,
  input  logic       En_Out_H,
  input  logic       En_Out_L,
  input  logic [1:0] Sel_out,
  output logic [3:0] Out_H,
  output logic [3:0] Out_L,
  output logic       Done_Calc_dp,
  output logic       Done_DIV_dp
);

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = 3;

`ifdef CALC_DP_DIVZERO_FAST_EN
  localparam bit DIVZERO_FAST = 1'b1;
`else
  localparam bit DIVZERO_FAST = 1'b0;
`endif

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  logic [W-1:0]  a_q, b_q, alu_q, alu_c;
  logic [PW-1:0] product;
  logic [W-1:0]  dv_q, dsr_q, rem_q, rem_nx, q_nx;
  logic [W:0]    rem_sh, diff;
  logic          take;
  logic [CW-1:0] cnt_q;
  div_state_t    div_st;
  logic [W-1:0]  out_h_q, out_l_q, src_h, src_l;

  // Operand registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (EN_X) a_q <= x;
      if (EN_Y) b_q <= y;
    end
  end

  assign product = PW'(a_q) * PW'(b_q);

  always_comb begin
    alu_c = '0;
    case (Op_Calc)
      2'b00:   alu_c = a_q + b_q;
      2'b01:   alu_c = a_q - b_q;
      2'b10:   alu_c = a_q & b_q;
      default: alu_c = a_q ^ b_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_q        <= '0;
      Done_Calc_dp <= 1'b0;
    end else if (EN_F) begin
      alu_q        <= '0;
      Done_Calc_dp <= 1'b0;
    end else if (Go_Calc) begin
      alu_q        <= alu_c;
      Done_Calc_dp <= 1'b1;
    end else begin
      Done_Calc_dp <= 1'b0;
    end
  end

  // One restoring step: shift next dividend bit into the remainder, subtract if it fits
  always_comb begin
    rem_sh = {rem_q, dv_q[W-1]};
    diff   = rem_sh - {1'b0, dsr_q};
    take   = (rem_sh >= {1'b0, dsr_q});
    rem_nx = take ? W'(diff) : W'(rem_sh);
    q_nx   = {dv_q[W-2:0], take};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_st      <= DIV_IDLE;
      dv_q        <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      Done_DIV_dp <= 1'b0;
    end else if (EN_F) begin
      div_st      <= DIV_IDLE;
      dv_q        <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      Done_DIV_dp <= 1'b0;
    end else begin
      case (div_st)
        DIV_IDLE: begin
          Done_DIV_dp <= 1'b0;
          if (Go_DIV) begin
            if (DIVZERO_FAST && (b_q == '0)) begin
              dv_q        <= '0;
              dsr_q       <= '0;
              rem_q       <= '0;
              div_st      <= DIV_DONE;
              Done_DIV_dp <= 1'b1;
            end else begin
              dv_q   <= a_q;
              dsr_q  <= b_q;
              rem_q  <= '0;
              cnt_q  <= CW'(W);
              div_st <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          if (!Go_DIV) begin
            div_st <= DIV_IDLE;
          end else begin
            rem_q <= rem_nx;
            dv_q  <= q_nx;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              div_st      <= DIV_DONE;
              Done_DIV_dp <= 1'b1;
              // Divide by zero reports zero quotient and remainder
              if (dsr_q == '0) begin
                rem_q <= '0;
                dv_q  <= '0;
              end
            end
          end
        end
        DIV_DONE: begin
          if (!Go_DIV) begin
            div_st      <= DIV_IDLE;
            Done_DIV_dp <= 1'b0;
          end
        end
        default: div_st <= DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    src_h = Sel_H ? product[PW-1:W] : rem_q;
    src_l = '0;
    case (Sel_L)
      2'b00:   src_l = '0;
      2'b01:   src_l = alu_q;
      2'b10:   src_l = product[W-1:0];
      default: src_l = dv_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_h_q <= '0;
      out_l_q <= '0;
    end else if (EN_F) begin
      out_h_q <= '0;
      out_l_q <= '0;
    end else begin
      if (En_Out_H) out_h_q <= src_h;
      if (En_Out_L) out_l_q <= src_l;
    end
  end

  always_comb begin
    Out_H = '0;
    Out_L = '0;
    case (Sel_out)
      2'b00:   ;
      2'b01: begin
        Out_H = out_h_q;
        Out_L = out_l_q;
      end
      2'b10:   Out_L = a_q;
      default: Out_L = b_q;
    endcase
  end

endmodule

// File: tb/tb_calc_dp.sv
// Scoreboard bench for calc_dp: expected outputs queued at stimulus time, checked on readout.
module tb_calc_dp;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] x, y;
  logic       EN_X, EN_Y, EN_F, Go_Calc, Go_DIV, Sel_H, En_Out_H, En_Out_L;
  logic [1:0] Op_Calc, Sel_L, Sel_out;
  logic [3:0] Out_H, Out_L;
  logic       Done_Calc_dp, Done_DIV_dp;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         errors  = 0;
  logic [3:0] oh_m, ol_m, a_m, b_m;

  calc_dp dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .EN_X(EN_X), .EN_Y(EN_Y), .EN_F(EN_F),
    .Go_Calc(Go_Calc), .Op_Calc(Op_Calc), .Go_DIV(Go_DIV), .Sel_H(Sel_H), .Sel_L(Sel_L),
    .En_Out_H(En_Out_H), .En_Out_L(En_Out_L), .Sel_out(Sel_out), .Out_H(Out_H), .Out_L(Out_L),
    .Done_Calc_dp(Done_Calc_dp), .Done_DIV_dp(Done_DIV_dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [3:0] h, input logic [3:0] l);
    exp_t e;
    e.tag = tag;
    e.val = {h, l};
    sb.push_back(e);
  endtask

  task automatic pop_out(input logic [1:0] sel);
    exp_t e;
    Sel_out = sel;
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, {Out_H, Out_L}, e.val);
    end
  endtask

  task automatic load_ab(input logic [3:0] a, input logic [3:0] b);
    x = a; y = b; EN_X = 1'b1; EN_Y = 1'b1;
    tick();
    EN_X = 1'b0; EN_Y = 1'b0;
    a_m = a; b_m = b;
  endtask

  function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    logic [4:0] s;
    case (op)
      2'b00: s = {1'b0, a} + {1'b0, b};
      2'b01: s = {1'b0, a} + {1'b0, ~b} + 5'd1;
      2'b10: s = {1'b0, a & b};
      default: s = {1'b0, a ^ b};
    endcase
    return s[3:0];
  endfunction

  task automatic alu_op(input string tag, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b);
    int n;
    load_ab(a, b);
    ol_m = alu_ref(op, a, b);
    push(tag, oh_m, ol_m);
    Op_Calc = op; Go_Calc = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!Done_Calc_dp && n < 10);
    chk({tag, "_lat"}, 8'(n), 8'd1);
    Sel_L = 2'b01; En_Out_L = 1'b1;
    tick();
    En_Out_L = 1'b0; Go_Calc = 1'b0;
    tick();
    chk({tag, "_done_clr"}, {7'd0, Done_Calc_dp}, 8'd0);
    pop_out(2'b01);
  endtask

  task automatic div_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input bit ld_x, input logic [3:0] nx);
    int n, lat;
    load_ab(a, b);
    oh_m = (b == 4'd0) ? 4'd0 : a % b;
    ol_m = (b == 4'd0) ? 4'd0 : a / b;
    push(tag, oh_m, ol_m);
`ifdef CALC_DP_DIVZERO_FAST_EN
    lat = (b == 4'd0) ? 1 : 5;
`else
    lat = 5;
`endif
    Go_DIV = 1'b1;
    if (ld_x) begin x = nx; EN_X = 1'b1; a_m = nx; end
    tick();
    EN_X = 1'b0;
    n = 1;
    while (!Done_DIV_dp && n < 20) begin tick(); n++; end
    chk({tag, "_lat"}, 8'(n), 8'(lat));
    Sel_H = 1'b0; Sel_L = 2'b11; En_Out_H = 1'b1; En_Out_L = 1'b1;
    tick();
    En_Out_H = 1'b0; En_Out_L = 1'b0; Go_DIV = 1'b0;
    tick();
    chk({tag, "_done_clr"}, {7'd0, Done_DIV_dp}, 8'd0);
    pop_out(2'b01);
  endtask

  initial begin
    int n;
    reset = 1'b0; x = '0; y = '0; EN_X = 0; EN_Y = 0; EN_F = 0; Go_Calc = 0; Go_DIV = 0;
    Sel_H = 0; En_Out_H = 0; En_Out_L = 0; Op_Calc = '0; Sel_L = '0; Sel_out = '0;
    oh_m = '0; ol_m = '0; a_m = '0; b_m = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    push("rst_out", 4'd0, 4'd0);
    pop_out(2'b01);
    chk("rst_done", {6'd0, Done_Calc_dp, Done_DIV_dp}, 8'd0);

    alu_op("add_9_5", 2'b00, 4'd9, 4'd5);
    alu_op("sub_9_5", 2'b01, 4'd9, 4'd5);
    alu_op("and_3_6", 2'b10, 4'd3, 4'd6);
    alu_op("xor_3_6", 2'b11, 4'd3, 4'd6);
    alu_op("sub_wrap", 2'b01, 4'd3, 4'd6);
    alu_op("add_wrap", 2'b00, 4'd12, 4'd7);

    // Multiplier via both output registers
    load_ab(4'd15, 4'd15);
    oh_m = 4'd14; ol_m = 4'd1;
    push("mul_15_15", oh_m, ol_m);
    Sel_H = 1'b1; Sel_L = 2'b10; En_Out_H = 1'b1; En_Out_L = 1'b1;
    tick();
    En_Out_H = 1'b0; En_Out_L = 1'b0;
    pop_out(2'b01);

    // Divider; A reloaded on the start edge must not affect this divide
    div_op("div_13_4", 4'd13, 4'd4, 1'b1, 4'd7);
    push("sel_a", 4'd0, a_m);
    pop_out(2'b10);
    push("sel_b", 4'd0, b_m);
    pop_out(2'b11);
    push("sel_zero", 4'd0, 4'd0);
    pop_out(2'b00);
    div_op("div_13_0", 4'd13, 4'd0, 1'b0, 4'd0);
    div_op("div_15_2", 4'd15, 4'd2, 1'b0, 4'd0);
    div_op("div_3_7", 4'd3, 4'd7, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      div_op("div_rand", 4'($urandom_range(15)), 4'($urandom_range(15)), 1'b0, 4'd0);
    end

    // Abort mid-divide, then a fresh divide takes the full time
    load_ab(4'd11, 4'd3);
    Go_DIV = 1'b1;
    repeat (2) tick();
    Go_DIV = 1'b0;
    tick();
    chk("abort_done", {7'd0, Done_DIV_dp}, 8'd0);
    div_op("div_after_abort", 4'd11, 4'd3, 1'b0, 4'd0);

    // EN_F wins over Go_Calc / Go_DIV and clears output registers
    EN_F = 1'b1; Go_Calc = 1'b1;
    tick();
    chk("enf_calc", {7'd0, Done_Calc_dp}, 8'd0);
    Go_Calc = 1'b0; Go_DIV = 1'b1;
    repeat (6) tick();
    chk("enf_div", {7'd0, Done_DIV_dp}, 8'd0);
    Go_DIV = 1'b0; EN_F = 1'b0;
    tick();
    oh_m = '0; ol_m = '0;
    push("enf_out", 4'd0, 4'd0);
    pop_out(2'b01);

    // Repopulate outputs, then reset in the middle of a divide
    alu_op("add_pre_rst", 2'b00, 4'd6, 4'd5);
    load_ab(4'd9, 4'd2);
    Go_DIV = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_done", {7'd0, Done_DIV_dp}, 8'd0);
    push("rst_mid_out", 4'd0, 4'd0);
    pop_out(2'b01);
    push("rst_mid_a", 4'd0, 4'd0);
    pop_out(2'b10);
    push("rst_mid_b", 4'd0, 4'd0);
    pop_out(2'b11);
    Go_DIV = 1'b0;
    tick();
    reset = 1'b1;
    oh_m = '0; ol_m = '0;
    tick();
    div_op("div_post_rst", 4'd9, 4'd2, 1'b0, 4'd0);

    n = sb.size();
    chk("sb_left", 8'(n), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
